// File: rtl/div_unit_if.sv
// div_unit_if.sv
// Interfaces between the execute stage and the iterative divider.
//
//   div_in_if  : operands and start request travelling into the divider
//       rdata1 [31:0]  dividend
//       rdata2 [31:0]  divisor
//       enable         start request (one rising edge with enable=1 starts an op)
//       div_op [3:0]   one-hot {div, divu, rem, remu}
//   div_out_if : completion travelling back to execute
//       result [31:0]  quotient or remainder of the latest completed op
//       ready          one-cycle completion pulse
//
// In both interfaces "master" is the execute-stage side and "slave" is the
// divider side.

interface div_in_if;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        enable;
    logic [3:0]  div_op;

    modport master (output rdata1, output rdata2, output enable, output div_op);
    modport slave  (input  rdata1, input  rdata2, input  enable, input  div_op);
endinterface

interface div_out_if;
    logic [31:0] result;
    logic        ready;

    modport master (input  result, input  ready);
    modport slave  (output result, output ready);
endinterface

// File: rtl/div_unit.sv
// div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Fixed latency: start edge N, 32 iteration edges N+1..N+32, ready high in
// the cycle after edge N+32. A start on any edge (IDLE, BUSY or DONE)
// aborts whatever is in flight and loads the new operands.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   div_in   operands, one-hot op and start request (div_in_if.slave)
//   div_out  registered result and one-cycle ready pulse (div_out_if.slave)

module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_in_if.slave    div_in,
    div_out_if.slave   div_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        ready_next;

    logic [4:0]  count;
    logic        is_quo;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [31:0] raw_a;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] result;
    logic        ready;

    logic        start;
    logic        op_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] final_result;

    assign start     = div_in.enable;
    assign op_signed = div_in.div_op[3] | div_in.div_op[1];
    assign a_mag     = (op_signed && div_in.rdata1[31]) ? -div_in.rdata1 : div_in.rdata1;
    assign b_mag     = (op_signed && div_in.rdata2[31]) ? -div_in.rdata2 : div_in.rdata2;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            ready <= ready_next;
        end
    end

    // Next state; a start request overrides every other transition.
    // ready is registered alongside the state so it has no path from div_in.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            BUSY:    if (count == 5'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start) begin
            state_next = BUSY;
        end
        ready_next = (state_next == DONE);
    end

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    // in 33 bits and keep the difference only when it did not go negative.
    always_comb begin
        shifted  = {rem, quo[31]};
        diff     = shifted - {1'b0, divisor};
        step_rem = shifted[31:0];
        step_quo = {quo[30:0], 1'b0};
        if (!diff[32]) begin
            step_rem = diff[31:0];
            step_quo = {quo[30:0], 1'b1};
        end
    end

    // Sign fix-up and divide-by-zero override applied to the final step.
    // -2^31 / -1 falls out naturally: magnitude quotient 0x80000000, no negation.
    always_comb begin
        if (is_quo) begin
            final_result = neg_q ? -step_quo : step_quo;
            if (dz) final_result = 32'hFFFF_FFFF;
        end else begin
            final_result = neg_r ? -step_rem : step_rem;
            if (dz) final_result = raw_a;
        end
    end

    // Datapath registers: load on start, iterate while busy, capture the
    // result on the last iteration and hold it until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 5'd0;
            is_quo  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            raw_a   <= 32'd0;
            divisor <= 32'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            result  <= 32'd0;
        end else if (start) begin
            count   <= 5'd31;
            is_quo  <= div_in.div_op[3] | div_in.div_op[2];
            neg_q   <= op_signed & (div_in.rdata1[31] ^ div_in.rdata2[31]);
            neg_r   <= op_signed & div_in.rdata1[31];
            dz      <= (div_in.rdata2 == 32'd0);
            raw_a   <= div_in.rdata1;
            divisor <= b_mag;
            quo     <= a_mag;
            rem     <= 32'd0;
        end else if (state == BUSY) begin
            rem <= step_rem;
            quo <= step_quo;
            if (count == 5'd0) begin
                result <= final_result;
            end else begin
                count <= count - 5'd1;
            end
        end
    end

    assign div_out.result = result;
    assign div_out.ready  = ready;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit.sv
// Self-checking bench for div_unit: directed sign/zero/overflow/abort/reset
// cases with constant expectations, then a back-to-back random run checked
// against a plain-arithmetic reference model.

module tb_div_unit;

    localparam logic [3:0] OP_DIV  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REM  = 4'b0010;
    localparam logic [3:0] OP_REMU = 4'b0001;
    localparam int NUM_RANDOM = 1000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_in_if  din ();
    div_out_if dout ();

    div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .div_in  (din.slave),
        .div_out (dout.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] held   = 32'd0;

    // Reference model: RISC-V division semantics from plain 64-bit arithmetic
    function automatic logic [31:0] refModel(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            OP_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            OP_REM:  return (b == 32'd0) ? a : 32'(sa % sb);
            default: return (b == 32'd0) ? a : 32'(ua % ub);
        endcase
    endfunction

    // Advance one cycle and land just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present operands with enable for exactly one start edge, then scramble
    // the operand bus to prove only the start-edge values are used
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        din.div_op = op;
        din.rdata1 = a;
        din.rdata2 = b;
        din.enable = 1'b1;
        tick();
        din.enable = 1'b0;
        din.rdata1 = $urandom;
        din.rdata2 = $urandom;
        din.div_op = 4'(1 << $urandom_range(0, 3));
    endtask

    // Wait (bounded) for ready; checks latency, result and that the previous
    // result stayed put while busy. Leaves the bench in the DONE cycle.
    task automatic awaitResult(input string tag, input logic [31:0] exp);
        int lat;
        logic stable;
        lat = 0;
        stable = 1'b1;
        while (dout.ready !== 1'b1 && lat < 40) begin
            if (dout.result !== held) stable = 1'b0;
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'd32);
        checkOutput({tag, " result"}, dout.result, exp);
        checkOutput({tag, " held"}, {31'd0, stable}, 32'd1);
        held = exp;
    endtask

    // Isolated op: also checks the ready pulse is one cycle wide
    task automatic runDirected(input string tag, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp);
        applyStimulus(op, a, b);
        awaitResult(tag, exp);
        tick();
        checkOutput({tag, " pulse end"}, {31'd0, dout.ready}, 32'd0);
        checkOutput({tag, " hold after"}, dout.result, exp);
    endtask

    initial begin
        int pulses;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        rst = 1'b1;
        din.enable = 1'b0;
        din.rdata1 = 32'd0;
        din.rdata2 = 32'd0;
        din.div_op = OP_DIVU;
        tick();
        tick();
        checkOutput("reset ready", {31'd0, dout.ready}, 32'd0);
        checkOutput("reset result", dout.result, 32'd0);

        // Reset wins over a simultaneous start
        din.rdata1 = 32'd100;
        din.rdata2 = 32'd7;
        din.enable = 1'b1;
        tick();
        din.enable = 1'b0;
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            if (dout.ready === 1'b1) pulses++;
            tick();
        end
        checkOutput("reset vs start pulses", 32'(pulses), 32'd0);
        checkOutput("reset vs start result", dout.result, 32'd0);

        $display("[TB] directed cases");
        runDirected("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        runDirected("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2);
        runDirected("div -7/2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        runDirected("rem -7/2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        runDirected("div 7/-2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        runDirected("rem 7/-2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
        runDirected("div 5/0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
        runDirected("divu 8m/0",  OP_DIVU, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
        runDirected("rem -5/0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        runDirected("remu 9/0",   OP_REMU, 32'd9, 32'd0, 32'd9);
        runDirected("div ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runDirected("rem ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Restart 10 cycles into a busy op: only the second one completes
        applyStimulus(OP_DIVU, 32'd1000, 32'd10);
        pulses = 0;
        repeat (9) begin
            if (dout.ready === 1'b1) pulses++;
            tick();
        end
        checkOutput("abort early pulses", 32'(pulses), 32'd0);
        runDirected("restart 81/9", OP_DIVU, 32'd81, 32'd9, 32'd9);

        // Reset in the middle of a busy op
        applyStimulus(OP_DIVU, 32'd50, 32'd5);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        held = 32'd0;
        pulses = 0;
        repeat (40) begin
            if (dout.ready === 1'b1) pulses++;
            tick();
        end
        checkOutput("mid-busy reset pulses", 32'(pulses), 32'd0);
        checkOutput("mid-busy reset result", dout.result, 32'd0);
        runDirected("after reset 77/7", OP_DIVU, 32'd77, 32'd7, 32'd11);

        // Back-to-back: each new start is issued in the DONE cycle, so every
        // pulse lands 33 cycles after the previous one
        $display("[TB] back-to-back random run");
        applyStimulus(OP_DIVU, 32'd1000, 32'd3);
        awaitResult("b2b first", 32'd333);
        applyStimulus(OP_REMU, 32'd1000, 32'd3);
        awaitResult("b2b second", 32'd1);
        for (int i = 0; i < NUM_RANDOM; i++) begin
            op = 4'(1 << $urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       begin a = $urandom; b = 32'd0; end
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       begin a = $urandom; b = 32'hFFFF_FFFF; end
                3:       begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
                4:       begin a = $urandom; b = $urandom_range(1, 255); end
                5:       begin a = 32'h8000_0000; b = $urandom; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            applyStimulus(op, a, b);
            awaitResult("random", refModel(op, a, b));
        end
        tick();
        checkOutput("final pulse end", {31'd0, dout.ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
